// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

    // Controller states: CLEAR sweeps the array to zero, READY serves traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NREAD = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register, an incremental population
// counter, and a pending lookup for every read port. The caller filters
// address 0 and qualifies the write/reserve strobes with the READY state.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int NREAD = RF_NREAD,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr_i,
    input  logic [AW-1:0]             clr_addr_i,
    input  logic                      we_i,
    input  logic [AW-1:0]             wa_i,
    input  logic                      rsv_i,
    input  logic [AW-1:0]             rsv_addr_i,
    input  logic [NREAD-1:0][AW-1:0]  ra_i,
    output logic [NREAD-1:0]          rpend_o,
    output logic [AW:0]               npend_o
);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [AW:0]      npend_q, npend_d;
    logic             set_s;
    logic             drop_s;

    // Next pending vector and counter; a reservation beats a same-address write.
    always_comb begin
        pend_d  = pend_q;
        npend_d = npend_q;
        set_s   = rsv_i && !pend_q[rsv_addr_i];
        drop_s  = we_i && pend_q[wa_i] && !(rsv_i && (rsv_addr_i == wa_i));
        for (int k = 0; k < DEPTH; k++) begin
            if (clr_i) begin
                pend_d[k] = (clr_addr_i == AW'(k)) ? 1'b0 : pend_q[k];
            end else begin
                pend_d[k] = (rsv_i && (rsv_addr_i == AW'(k))) ? 1'b1 :
                            (we_i  && (wa_i       == AW'(k))) ? 1'b0 : pend_q[k];
            end
        end
        if (clr_i) begin
            npend_d = '0;
        end else begin
            case ({set_s, drop_s})
                2'b10:   npend_d = npend_q + {{AW{1'b0}}, 1'b1};
                2'b01:   npend_d = npend_q - {{AW{1'b0}}, 1'b1};
                default: npend_d = npend_q;
            endcase
        end
    end

    // Pending state register; the bit vector itself is zeroed by the clear sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            npend_q <= '0;
        end else begin
            pend_q  <= pend_d;
            npend_q <= npend_d;
        end
    end

    // Per-port pending lookup.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rpend_o[i] = pend_q[ra_i[i]];
        end
    end

    assign npend_o = npend_q;

endmodule

// File: rtl/regfile_param.sv
// Multi-read-port register file with pending scoreboard and clear sequencer.
// Register 0 reads as zero and ignores writes/reservations.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to readers.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int NREAD = RF_NREAD,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        busy,
    input  logic                        we,
    input  logic [AW-1:0]               wa,
    input  logic [WIDTH-1:0]            wd,
    input  logic                        rsv_en,
    input  logic [AW-1:0]               rsv_addr,
    input  logic [NREAD-1:0][AW-1:0]    ra,
    output logic [NREAD-1:0][WIDTH-1:0] rd,
    output logic [NREAD-1:0]            rpend,
    output logic [AW:0]                 npend
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rf_q [DEPTH];
    logic             clearing_s;
    logic             wr_ok_s;
    logic             rsv_ok_s;
    logic [NREAD-1:0] sb_rpend_s;

    assign clearing_s = (state_q == CLEAR);
    assign wr_ok_s    = (state_q == READY) && !reset && we && (wa != '0);
    assign rsv_ok_s   = (state_q == READY) && !reset && rsv_en && (rsv_addr != '0);
    assign busy       = clearing_s;

    // Controller state and sweep counter; reset restarts the sweep at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep one register per cycle, leave CLEAR after the last index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d   = cnt_q + AW'(1);
                state_d = (cnt_q == LAST) ? READY : CLEAR;
            end
            READY: begin
                cnt_d   = '0;
                state_d = READY;
            end
            default: begin
                cnt_d   = '0;
                state_d = CLEAR;
            end
        endcase
    end

    // Data array: zeroed by the sweep, otherwise written from writeback.
    always_ff @(posedge clk) begin
        if (!reset && clearing_s) begin
            rf_q[cnt_q] <= '0;
        end else if (wr_ok_s) begin
            rf_q[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NREAD (NREAD)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (clearing_s),
        .clr_addr_i (cnt_q),
        .we_i       (wr_ok_s),
        .wa_i       (wa),
        .rsv_i      (rsv_ok_s),
        .rsv_addr_i (rsv_addr),
        .ra_i       (ra),
        .rpend_o    (sb_rpend_s),
        .npend_o    (npend)
    );

    // Combinational read ports; everything reads zero while clearing or at r0.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            if ((state_q == READY) && (ra[i] != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_ok_s && (wa == ra[i])) begin
                    rd[i]    = wd;
                    rpend[i] = rsv_ok_s && (rsv_addr == wa);
                end else begin
                    rd[i]    = rf_q[ra[i]];
                    rpend[i] = sb_rpend_s[i];
                end
`else
                rd[i]    = rf_q[ra[i]];
                rpend[i] = sb_rpend_s[i];
`endif
            end else begin
                rd[i]    = '0;
                rpend[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param (default 32x32, two read ports).
module tb_regfile_param;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             busy;
    logic             we = 1'b0;
    logic [4:0]       wa = 5'd0;
    logic [31:0]      wd = 32'd0;
    logic             rsv_en = 1'b0;
    logic [4:0]       rsv_addr = 5'd0;
    logic [1:0][4:0]  ra = '0;
    logic [1:0][31:0] rd;
    logic [1:0]       rpend;
    logic [5:0]       npend;

    int tests = 0;
    int fails = 0;
    int n;

    regfile_param dut (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .ra       (ra),
        .rd       (rd),
        .rpend    (rpend),
        .npend    (npend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ra[0] = 5'd5;
        ra[1] = 5'd0;
        repeat (3) step();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b expected 1", busy); end
        tests++;
        if (npend !== 6'd0) begin fails++; $display("FAIL rst_npend: got %0d expected 0", npend); end
        tests++;
        if (rd[0] !== 32'd0 || rpend[0] !== 1'b0) begin
            fails++; $display("FAIL rst_read: got %h/%b expected 0/0", rd[0], rpend[0]);
        end
        reset = 1'b0;
        count_busy();
        tests++;
        if (n != 32) begin fails++; $display("FAIL rst_busy_len: got %0d expected 32", n); end
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a);
            ra[1] = 5'(31 - a);
            #1;
            tests++;
            if (rd[0] !== 32'd0 || rd[1] !== 32'd0 || rpend !== 2'b00) begin
                fails++; $display("FAIL rst_clean a=%0d: got %h %h %b expected 0 0 00", a, rd[0], rd[1], rpend);
            end
        end
        tests++;
        if (npend !== 6'd0) begin fails++; $display("FAIL rst_npend_ready: got %0d expected 0", npend); end
    endtask

    task automatic test_write();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        we = 1'b0;
        ra[0] = 5'd5; ra[1] = 5'd5;
        #1;
        tests++;
        if (rd[0] !== 32'hDEADBEEF || rd[1] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL wr_r5: got %h %h expected deadbeef deadbeef", rd[0], rd[1]);
        end
        we = 1'b1; wa = 5'd0; wd = 32'h1234;
        step();
        we = 1'b0;
        ra[0] = 5'd0; ra[1] = 5'd0;
        #1;
        tests++;
        if (rd[0] !== 32'd0 || rd[1] !== 32'd0) begin
            fails++; $display("FAIL wr_r0: got %h %h expected 0 0", rd[0], rd[1]);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        step();
        rsv_addr = 5'd9;
        step();
        rsv_en = 1'b0;
        ra[0] = 5'd7; ra[1] = 5'd9;
        #1;
        tests++;
        if (npend !== 6'd2) begin fails++; $display("FAIL sb_npend2: got %0d expected 2", npend); end
        tests++;
        if (rpend !== 2'b11) begin fails++; $display("FAIL sb_rpend79: got %b expected 11", rpend); end
        // retire r7
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
        step();
        we = 1'b0;
        #1;
        tests++;
        if (npend !== 6'd1) begin fails++; $display("FAIL sb_npend_w7: got %0d expected 1", npend); end
        tests++;
        if (rpend[0] !== 1'b0 || rd[0] !== 32'h77) begin
            fails++; $display("FAIL sb_r7: got %h/%b expected 77/0", rd[0], rpend[0]);
        end
        // reserve and write r9 together: new producer wins
        we = 1'b1; wa = 5'd9; wd = 32'h0000_0099; rsv_en = 1'b1; rsv_addr = 5'd9;
        step();
        we = 1'b0; rsv_en = 1'b0;
        #1;
        tests++;
        if (rpend[1] !== 1'b1 || rd[1] !== 32'h99 || npend !== 6'd1) begin
            fails++; $display("FAIL sb_r9_same: got %h/%b/%0d expected 99/1/1", rd[1], rpend[1], npend);
        end
        // write r9 (pending) while reserving r11: net zero
        we = 1'b1; wa = 5'd9; wd = 32'h0000_0999; rsv_en = 1'b1; rsv_addr = 5'd11;
        step();
        we = 1'b0; rsv_en = 1'b0;
        ra[0] = 5'd11;
        #1;
        tests++;
        if (npend !== 6'd1 || rpend !== 2'b01) begin
            fails++; $display("FAIL sb_net0: got %0d/%b expected 1/01", npend, rpend);
        end
        // re-reserve r11, write non-pending r5, reserve r0: count unchanged
        rsv_en = 1'b1; rsv_addr = 5'd11;
        step();
        rsv_addr = 5'd0; we = 1'b1; wa = 5'd5; wd = 32'h0000_0055;
        step();
        rsv_en = 1'b0; we = 1'b0;
        ra[0] = 5'd0; ra[1] = 5'd5;
        #1;
        tests++;
        if (npend !== 6'd1) begin fails++; $display("FAIL sb_npend_hold: got %0d expected 1", npend); end
        tests++;
        if (rpend !== 2'b00 || rd[1] !== 32'h55 || rd[0] !== 32'd0) begin
            fails++; $display("FAIL sb_r0_r5: got %b %h %h expected 00 0 55", rpend, rd[0], rd[1]);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd3; wd = 32'h1111_1111;
        step();
        wd = 32'hA5A5A5A5;
        ra[0] = 5'd5; ra[1] = 5'd3;
        #1;
        tests++;
`ifdef REGFILE_BYPASS_EN
        if (rd[1] !== 32'hA5A5A5A5 || rpend[1] !== 1'b0) begin
            fails++; $display("FAIL byp_same: got %h/%b expected a5a5a5a5/0", rd[1], rpend[1]);
        end
`else
        if (rd[1] !== 32'h1111_1111 || rpend[1] !== 1'b0) begin
            fails++; $display("FAIL byp_same: got %h/%b expected 11111111/0", rd[1], rpend[1]);
        end
`endif
        step();
        we = 1'b0;
        #1;
        tests++;
        if (rd[1] !== 32'hA5A5A5A5) begin fails++; $display("FAIL byp_next: got %h expected a5a5a5a5", rd[1]); end
        // write plus reservation of the same register
        we = 1'b1; wa = 5'd3; wd = 32'h5A5A_5A5A; rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        tests++;
`ifdef REGFILE_BYPASS_EN
        if (rd[1] !== 32'h5A5A_5A5A || rpend[1] !== 1'b1) begin
            fails++; $display("FAIL byp_rsv: got %h/%b expected 5a5a5a5a/1", rd[1], rpend[1]);
        end
`else
        if (rd[1] !== 32'hA5A5A5A5 || rpend[1] !== 1'b0) begin
            fails++; $display("FAIL byp_rsv: got %h/%b expected a5a5a5a5/0", rd[1], rpend[1]);
        end
`endif
        step();
        we = 1'b0; rsv_en = 1'b0;
        #1;
        tests++;
        if (rd[1] !== 32'h5A5A_5A5A || rpend[1] !== 1'b1 || npend !== 6'd2) begin
            fails++; $display("FAIL byp_rsv_next: got %h/%b/%0d expected 5a5a5a5a/1/2", rd[1], rpend[1], npend);
        end
    endtask

    task automatic test_reset_midclear();
        we = 1'b1; wa = 5'd12; wd = 32'hCAFE_F00D;
        step();
        we = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();
        ra[0] = 5'd12; ra[1] = 5'd3;
        #1;
        tests++;
        if (busy !== 1'b1 || npend !== 6'd0 || rd[0] !== 32'd0 || rpend !== 2'b00) begin
            fails++; $display("FAIL mid_clear: got %b/%0d/%h/%b expected 1/0/0/00", busy, npend, rd[0], rpend);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy();
        tests++;
        if (n != 32) begin fails++; $display("FAIL mid_busy_len: got %0d expected 32", n); end
        for (int a = 0; a < 32; a += 2) begin
            ra[0] = 5'(a);
            ra[1] = 5'(a + 1);
            #1;
            tests++;
            if (rd[0] !== 32'd0 || rd[1] !== 32'd0 || rpend !== 2'b00) begin
                fails++; $display("FAIL mid_clean a=%0d: got %h %h %b expected 0 0 00", a, rd[0], rd[1], rpend);
            end
        end
        tests++;
        if (npend !== 6'd0) begin fails++; $display("FAIL mid_npend: got %0d expected 0", npend); end
    endtask

    task automatic test_clear_ignore();
        reset = 1'b1;
        step();
        reset = 1'b0;
        we = 1'b1; wa = 5'd4; wd = 32'h0000_FFFF; rsv_en = 1'b1; rsv_addr = 5'd4;
        count_busy();
        we = 1'b0; rsv_en = 1'b0;
        tests++;
        if (n != 32) begin fails++; $display("FAIL ign_busy_len: got %0d expected 32", n); end
        ra[0] = 5'd4; ra[1] = 5'd4;
        #1;
        tests++;
        if (rd[0] !== 32'd0 || rpend !== 2'b00 || npend !== 6'd0) begin
            fails++; $display("FAIL ign_r4: got %h/%b/%0d expected 0/00/0", rd[0], rpend, npend);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_scoreboard();
        test_bypass();
        test_reset_midclear();
        test_clear_ignore();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
